// File: rtl/win_check_ctrl.sv
// Five-in-a-row check sequencer: walks the board RAM outward from the last stone in 4 directions.
// Latency: 2 cycles per read (ISSUE, EVAL) plus INIT, NEXT_DIR and DONE cycles; 2 cycles for an off-board origin.
// Backpressure: none; start is taken only in IDLE, and start while busy or in the DONE cycle is dropped.
//
// Build option: define EXACT_FIVE_EN for the exact-five rule. Each side then walks up to WIN_LEN
// steps, and the win test (count == WIN_LEN) runs at the end of each direction. Without the
// macro, any run >= WIN_LEN wins and the scan exits at once.
//
// Ports:
//   clock_i, reset_i        rising-edge clock, synchronous active-high reset
//   start_i, x_i, y_i,      one-cycle request with the last stone's coordinate and colour
//   player_i                (0 -> cell code 01, 1 -> cell code 10)
//   mem_rd_o, mem_addr_o    board RAM read strobe and address (y*BOARD_W + x)
//   mem_rdata_i             cell code, valid the cycle after mem_rd_o
//   busy_o, done_o          scan in progress; one-cycle result-valid pulse
//   win_o, win_dir_o        result, held until the next accepted start
module win_check_ctrl #(
    parameter int BOARD_W = 15,
    parameter int BOARD_H = 15,
    parameter int WIN_LEN = 5,
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic               player_i,
    output logic               mem_rd_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [1:0]         mem_rdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               win_o,
    output logic [1:0]         win_dir_o
);

    // Two spare bits: one for sign, one so origin + WIN_LEN past the far edge cannot overflow.
    localparam int OFF_W  = COORD_W + 2;
    localparam int CNT_W  = $clog2(2*WIN_LEN+1);
    localparam int STEP_W = $clog2(WIN_LEN+1);
`ifdef EXACT_FIVE_EN
    localparam int STEP_LIM = WIN_LEN;
`else
    localparam int STEP_LIM = WIN_LEN - 1;
`endif
    localparam logic [STEP_W-1:0]       STEP_MAX = STEP_W'(STEP_LIM);
    localparam logic [CNT_W-1:0]        WIN_CNT  = CNT_W'(WIN_LEN);
    localparam logic [CNT_W-1:0]        CNT_SAT  = '1;
    localparam logic signed [OFF_W-1:0] BW_S     = OFF_W'(BOARD_W);
    localparam logic signed [OFF_W-1:0] BH_S     = OFF_W'(BOARD_H);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_ISSUE, ST_EVAL, ST_NEXT_DIR, ST_DONE
    } state_t;

    // Read request for the cell the next ISSUE cycle targets; vld doubles as mem_rd.
    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
    } rd_req_t;

    state_t             state_q;
    logic [COORD_W-1:0] ox_q, oy_q;
    logic               player_q;
    logic [1:0]         dir_q;
    logic               neg_q;      // 0: walking the + side, 1: the - side
    logic [STEP_W-1:0]  step_q;
    logic [CNT_W-1:0]   count_q;
    rd_req_t            rd_req_q;
    logic               busy_q, done_q, win_q;
    logic [1:0]         win_dir_q;

    logic               match;
    logic [CNT_W-1:0]   count_inc;
    logic               win_now;
    logic               walk_on;
    logic               origin_bad;

    // Cell at origin + side*step*vec(dir); vld clear when it falls off the board.
    function automatic rd_req_t tgt(input logic [COORD_W-1:0] ox, input logic [COORD_W-1:0] oy,
                                    input logic [1:0] dir, input logic neg,
                                    input logic [STEP_W-1:0] step);
        logic signed [OFF_W-1:0] cx, cy, st;
        logic                    ypos;
        rd_req_t                 r;
        st = OFF_W'(step);
        cx = OFF_W'(ox);
        cy = OFF_W'(oy);
        // Every direction except vertical moves +x on the + side.
        if (dir != 2'd1) cx = neg ? cx - st : cx + st;
        // Anti-diagonal is the only direction whose + side moves -y.
        ypos = (dir != 2'd3) ^ neg;
        if (dir != 2'd0) cy = ypos ? cy + st : cy - st;
        r.vld  = !cx[OFF_W-1] && !cy[OFF_W-1] && (cx < BW_S) && (cy < BH_S);
        r.addr = r.vld ? ADDR_W'(cy) * ADDR_W'(BOARD_W) + ADDR_W'(cx) : '0;
        return r;
    endfunction

    assign match      = (mem_rdata_i == {player_q, ~player_q});
    assign count_inc  = (count_q == CNT_SAT) ? count_q : count_q + CNT_W'(1);
    assign walk_on    = match && (step_q != STEP_MAX);
    assign origin_bad = ($signed(OFF_W'(ox_q)) >= BW_S) || ($signed(OFF_W'(oy_q)) >= BH_S);
`ifdef EXACT_FIVE_EN
    assign win_now    = 1'b0;
`else
    assign win_now    = match && (count_inc >= WIN_CNT);
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            ox_q      <= '0;
            oy_q      <= '0;
            player_q  <= 1'b0;
            dir_q     <= 2'd0;
            neg_q     <= 1'b0;
            step_q    <= '0;
            count_q   <= '0;
            rd_req_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            win_dir_q <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ox_q      <= x_i;
                        oy_q      <= y_i;
                        player_q  <= player_i;
                        win_q     <= 1'b0;
                        win_dir_q <= 2'd0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (origin_bad) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        dir_q    <= 2'd0;
                        neg_q    <= 1'b0;
                        step_q   <= STEP_W'(1);
                        count_q  <= CNT_W'(1);
                        rd_req_q <= tgt(ox_q, oy_q, 2'd0, 1'b0, STEP_W'(1));
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rd_req_q.vld) begin
                        rd_req_q.vld <= 1'b0;
                        state_q      <= ST_EVAL;
                    end else if (!neg_q) begin
                        neg_q    <= 1'b1;
                        step_q   <= STEP_W'(1);
                        rd_req_q <= tgt(ox_q, oy_q, dir_q, 1'b1, STEP_W'(1));
                    end else begin
                        state_q <= ST_NEXT_DIR;
                    end
                end
                ST_EVAL: begin
                    if (match) count_q <= count_inc;
                    if (win_now) begin
                        win_q     <= 1'b1;
                        win_dir_q <= dir_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (walk_on) begin
                        step_q   <= step_q + STEP_W'(1);
                        rd_req_q <= tgt(ox_q, oy_q, dir_q, neg_q, step_q + STEP_W'(1));
                        state_q  <= ST_ISSUE;
                    end else if (!neg_q) begin
                        neg_q    <= 1'b1;
                        step_q   <= STEP_W'(1);
                        rd_req_q <= tgt(ox_q, oy_q, dir_q, 1'b1, STEP_W'(1));
                        state_q  <= ST_ISSUE;
                    end else begin
                        state_q <= ST_NEXT_DIR;
                    end
                end
                ST_NEXT_DIR: begin
`ifdef EXACT_FIVE_EN
                    // Overlines fall through and the scan carries on.
                    if (count_q == WIN_CNT) begin
                        win_q     <= 1'b1;
                        win_dir_q <= dir_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else
`endif
                    if (dir_q == 2'd3) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        dir_q    <= dir_q + 2'd1;
                        neg_q    <= 1'b0;
                        step_q   <= STEP_W'(1);
                        count_q  <= CNT_W'(1);
                        rd_req_q <= tgt(ox_q, oy_q, dir_q + 2'd1, 1'b0, STEP_W'(1));
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_rd_o   = rd_req_q.vld;
    assign mem_addr_o = rd_req_q.addr;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign win_o      = win_q;
    assign win_dir_o  = win_dir_q;

endmodule

// File: tb/tb_win_check_ctrl.sv
// Bench for win_check_ctrl: board RAM model with 1-cycle read latency, table of scan vectors
// with hand-derived results, and hand-written sequences for reset abort and ignored starts.
module tb_win_check_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [3:0] x_i, y_i;
    logic       player_i;
    logic       mem_rd_o;
    logic [7:0] mem_addr_o;
    logic [1:0] mem_rdata_i;
    logic       busy_o, done_o, win_o;
    logic [1:0] win_dir_o;

    always #5 clk = ~clk;

    win_check_ctrl dut (
        .clock_i    (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .x_i        (x_i),
        .y_i        (y_i),
        .player_i   (player_i),
        .mem_rd_o   (mem_rd_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .win_o      (win_o),
        .win_dir_o  (win_dir_o)
    );

    // Board RAM: 15x15 cells, address y*15+x, data the cycle after the strobe.
    logic [1:0] board [0:224];
    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata_i <= (mem_addr_o < 8'd225) ? board[mem_addr_o] : 2'b11;
    end

    typedef struct {int bid; int x; int y; int p; int ew; int ed; int er; int ecyc;} vec_t;
    typedef struct {int ew; int ed; int er;} exp_t;

    vec_t vt[11];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exact = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic put(input int x, input int y, input logic [1:0] code);
        board[y*15 + x] = code;
    endtask

    task automatic setup_board(input int bid);
        for (int i = 0; i < 225; i++) board[i] = 2'b00;
        case (bid)
            1: for (int i = 3; i <= 7; i++) put(i, 7, 2'b01);
            2: for (int i = 0; i < 5; i++) put(10 + i, 4 - i, 2'b10);
            3: for (int i = 2; i <= 7; i++) put(i, 5, 2'b01);
            4: for (int i = 10; i <= 14; i++) put(0, i, 2'b10);
            5: for (int i = 0; i < 5; i++) put(i, i, 2'b01);
            6: begin
                put(3, 7, 2'b01); put(4, 7, 2'b01); put(6, 7, 2'b01);
                put(7, 7, 2'b01); put(8, 7, 2'b01);
            end
            7: begin
                put(12, 3, 2'b01); put(13, 3, 2'b01); put(14, 3, 2'b01);
                put(0, 4, 2'b01);  put(1, 4, 2'b01);  put(11, 3, 2'b11);
            end
            default: ;
        endcase
    endtask

    // One scan: push expectation, start, count reads until done, pop and compare.
    // poke > 0 pulses a conflicting start on that busy cycle; poke_done pulses start in the DONE cycle.
    task automatic run_one(input vec_t v, input int poke, input bit poke_done);
        exp_t e;
        int   reads, cyc;
        bit   got;
        setup_board(v.bid);
        @(posedge clk); #1;
        start_i = 1'b1; x_i = 4'(v.x); y_i = 4'(v.y); player_i = v.p[0];
        exp_q.push_back('{v.ew, v.ed, v.er});
        @(posedge clk); #1;
        start_i = 1'b0; x_i = 4'd0; y_i = 4'd0; player_i = ~v.p[0];
        reads = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (poke > 0 && cyc == poke) begin
                start_i = 1'b1; x_i = 4'd15; y_i = 4'd0;
            end else if (poke > 0 && cyc == poke + 1) begin
                start_i = 1'b0;
            end
            if (cyc == 1) begin
                chk("busy_after_start", int'(busy_o), 1);
                chk("win_cleared_on_start", int'(win_o), 0);
            end
            if (mem_rd_o) begin
                reads++;
                chk("addr_on_board", int'(mem_addr_o < 8'd225), 1);
            end
            if (done_o) begin
                got = 1'b1;
                e = exp_q.pop_front();
                chk("win", int'(win_o), e.ew);
                chk("win_dir", int'(win_dir_o), e.ed);
                chk("read_count", reads, e.er);
                chk("busy_at_done", int'(busy_o), 0);
                if (v.ecyc > 0) chk("done_latency", cyc, v.ecyc);
                if (poke_done) begin
                    start_i = 1'b1; x_i = 4'd15; y_i = 4'd15;
                end
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", cyc);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("done_one_cycle", int'(done_o), 0);
        chk("win_held", int'(win_o), v.ew);
        if (poke_done) chk("start_in_done_ignored", int'(busy_o), 0);
    endtask

    initial begin
        int reads, cyc, dn, rd;
`ifdef EXACT_FIVE_EN
        exact = 1;
`endif
        //          bid  x   y  p  win dir reads                     done cycle
        vt[0]  = '{1,   7,  7, 0, 1,  0,  (exact != 0) ? 6 : 5,   -1};
        vt[1]  = '{0,   0,  0, 0, 0,  0,  3,                      -1};
        vt[2]  = '{2,  14,  0, 1, 1,  3,  (exact != 0) ? 7 : 6,   -1};
        vt[3]  = '{3,   7,  5, 0, (exact != 0) ? 0 : 1, 0, (exact != 0) ? 12 : 5, -1};
        vt[4]  = '{4,   0, 14, 1, 1,  1,  (exact != 0) ? 6 : 5,   -1};
        vt[5]  = '{1,   7,  7, 1, 0,  0,  8,                      -1};
        vt[6]  = '{5,   2,  2, 0, 1,  2,  9,                      -1};
        vt[7]  = '{6,   6,  7, 0, 0,  0,  10,                     -1};
        vt[8]  = '{7,  14,  3, 0, 0,  0,  7,                      -1};
        vt[9]  = '{0,  15,  3, 0, 0,  0,  0,                       2};
        vt[10] = '{0,   3, 15, 0, 0,  0,  0,                       2};

        reset_i = 1'b1; start_i = 1'b0; x_i = 4'd0; y_i = 4'd0; player_i = 1'b0;
        setup_board(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_rd", int'(mem_rd_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_win", int'(win_o), 0);
        chk("reset_win_dir", int'(win_dir_o), 0);
        reset_i = 1'b0;

        for (int i = 0; i < 11; i++) run_one(vt[i], 0, 1'b0);

        // Start pulsed while busy must not disturb the running scan; start in DONE is dropped.
        run_one(vt[0], 3, 1'b1);

        // Reset during the third read aborts the scan with no done and no further reads.
        setup_board(1);
        @(posedge clk); #1;
        start_i = 1'b1; x_i = 4'd7; y_i = 4'd7; player_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        reads = 0; cyc = 0;
        while (reads < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_rd_o) reads++;
        end
        chk("third_read_reached", reads, 3);
        reset_i = 1'b1;
        @(negedge clk);
        chk("abort_mem_rd", int'(mem_rd_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_done", int'(done_o), 0);
        reset_i = 1'b0;
        dn = 0; rd = 0;
        repeat (20) begin
            @(negedge clk);
            dn += int'(done_o);
            rd += int'(mem_rd_o);
        end
        chk("no_done_after_abort", dn, 0);
        chk("no_read_after_abort", rd, 0);
        run_one(vt[0], 0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
